// File: rtl/run_ctrl_fsm.sv
// Run-length sequencer: repeat_cnt+1 passes of max(run_len,1) cycles, then a one-cycle done.
// Optional abort support is compiled in with `define RUN_CTRL_ABORT_EN.
module run_ctrl_fsm #(
   parameter int CNT_W = 8,
   parameter int REP_W = 4
) (
   input  logic             clk,
   input  logic             reset_n,
   input  logic             start,
   input  logic [CNT_W-1:0] run_len,
   input  logic [REP_W-1:0] repeat_cnt,
   input  logic             abort,
   output logic             busy,
   output logic             done,
   output logic [1:0]       state_out,
   output logic [CNT_W-1:0] cycle_cnt,
   output logic [REP_W-1:0] pass_cnt
);

   typedef enum logic [1:0] {
      S_IDLE = 2'b00,
      S_RUN  = 2'b01,
      S_FIN  = 2'b10,
      S_ABT  = 2'b11
   } state_e;

   state_e           state_q, state_d;
   logic [CNT_W-1:0] cyc_q, cyc_d, len_q, len_d, last_cyc;
   logic [REP_W-1:0] pass_q, pass_d, rep_q, rep_d;
   logic             busy_q, done_q;

   // run_len of zero behaves as a one-cycle pass
   assign last_cyc = (len_q == '0) ? '0 : len_q - CNT_W'(1);

`ifndef RUN_CTRL_ABORT_EN
   logic unused_abort;
   assign unused_abort = abort;
`endif

   always_comb begin
      state_d = state_q;
      cyc_d   = cyc_q;
      pass_d  = pass_q;
      len_d   = len_q;
      rep_d   = rep_q;
      case (state_q)
         S_IDLE: begin
            if (start) begin
               state_d = S_RUN;
               cyc_d   = '0;
               pass_d  = '0;
               len_d   = run_len;
               rep_d   = repeat_cnt;
            end
         end
         S_RUN: begin
            if (cyc_q == last_cyc) begin
               if (pass_q < rep_q) begin
                  cyc_d  = '0;
                  pass_d = pass_q + REP_W'(1);
               end else begin
                  state_d = S_FIN;
               end
            end else begin
               cyc_d = cyc_q + CNT_W'(1);
            end
`ifdef RUN_CTRL_ABORT_EN
            // abort wins over the pass-end transition; counters freeze where they are
            if (abort) begin
               state_d = S_ABT;
               cyc_d   = cyc_q;
               pass_d  = pass_q;
            end
`endif
         end
         S_FIN:   state_d = S_IDLE;
`ifdef RUN_CTRL_ABORT_EN
         S_ABT:   state_d = S_IDLE;
`endif
         default: state_d = S_IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state_q <= S_IDLE;
         cyc_q   <= '0;
         pass_q  <= '0;
         len_q   <= '0;
         rep_q   <= '0;
         busy_q  <= 1'b0;
         done_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         cyc_q   <= cyc_d;
         pass_q  <= pass_d;
         len_q   <= len_d;
         rep_q   <= rep_d;
         busy_q  <= (state_d == S_RUN);
         done_q  <= (state_d == S_FIN);
      end
   end

   assign busy      = busy_q;
   assign done      = done_q;
   assign state_out = state_q;
   assign cycle_cnt = cyc_q;
   assign pass_cnt  = pass_q;

endmodule

// File: tb/tb_run_ctrl_fsm.sv
// Scoreboard bench for run_ctrl_fsm: stimulus queues per-cycle expectations, a negedge monitor checks them.
module tb_run_ctrl_fsm;

   logic       clk = 1'b0;
   logic       reset_n;
   logic       start;
   logic [7:0] run_len;
   logic [3:0] repeat_cnt;
   logic       abort;
   logic       busy, done;
   logic [1:0] state_out;
   logic [7:0] cycle_cnt;
   logic [3:0] pass_cnt;

   localparam logic [1:0] IDLE = 2'b00, RUN = 2'b01, FIN = 2'b10, ABT = 2'b11;

   typedef struct packed {
      logic [1:0] st;
      logic [7:0] cyc;
      logic [3:0] pas;
      logic       busy;
      logic       done;
   } obs_t;

   typedef struct {
      obs_t o;
      int   tag;
   } exp_t;

   exp_t exp_q[$];
   int   total = 0;
   int   bad   = 0;

   run_ctrl_fsm #(.CNT_W(8), .REP_W(4)) dut (
      .clk(clk), .reset_n(reset_n), .start(start), .run_len(run_len),
      .repeat_cnt(repeat_cnt), .abort(abort), .busy(busy), .done(done),
      .state_out(state_out), .cycle_cnt(cycle_cnt), .pass_cnt(pass_cnt)
   );

   always #5 clk = ~clk;

   task automatic push(input int tag, input logic [1:0] st, input logic [7:0] cyc,
                       input logic [3:0] pas, input logic b, input logic d);
      exp_t e;
      e.o   = '{st: st, cyc: cyc, pas: pas, busy: b, done: d};
      e.tag = tag;
      exp_q.push_back(e);
   endtask

   // monitor: one expected observation per cycle while the scoreboard holds entries
   always @(negedge clk) begin
      if (exp_q.size() > 0) begin
         exp_t e;
         obs_t a;
         e = exp_q.pop_front();
         a = '{st: state_out, cyc: cycle_cnt, pas: pass_cnt, busy: busy, done: done};
         total++;
         if (a !== e.o) begin
            bad++;
            $display("FAIL test%0d cycle: got st=%0d cyc=%0d pass=%0d busy=%b done=%b, want st=%0d cyc=%0d pass=%0d busy=%b done=%b",
                     e.tag, a.st, a.cyc, a.pas, a.busy, a.done,
                     e.o.st, e.o.cyc, e.o.pas, e.o.busy, e.o.done);
         end
      end
   end

   task automatic drain(input int tag);
      for (int i = 0; i < 200 && exp_q.size() != 0; i++) @(posedge clk);
      if (exp_q.size() != 0) begin
         total++;
         bad++;
         $display("FAIL test%0d drain: %0d entries left, want 0", tag, exp_q.size());
         exp_q.delete();
      end
   endtask

   // one full sequence; optionally abort on the final RUNNING cycle
   task automatic run_seq(input int tag, input logic [7:0] len, input logic [3:0] rep,
                          input bit abort_last);
      int L;
      L = (len == 0) ? 1 : int'(len);
      @(posedge clk); #1;
      start = 1'b1; run_len = len; repeat_cnt = rep;
      @(posedge clk); #1;
      start = 1'b0; run_len = 8'hAA; repeat_cnt = 4'hF;
      for (int p = 0; p <= int'(rep); p++)
         for (int c = 0; c < L; c++)
            push(tag, RUN, 8'(c), 4'(p), 1'b1, 1'b0);
`ifdef RUN_CTRL_ABORT_EN
      if (abort_last) push(tag, ABT, 8'(L-1), rep, 1'b0, 1'b0);
      else            push(tag, FIN, 8'(L-1), rep, 1'b0, 1'b1);
`else
      push(tag, FIN, 8'(L-1), rep, 1'b0, 1'b1);
`endif
      push(tag, IDLE, 8'(L-1), rep, 1'b0, 1'b0);
      if (abort_last) begin
         repeat ((int'(rep) + 1) * L - 1) @(posedge clk);
         #1 abort = 1'b1;
         @(posedge clk);
         @(posedge clk); #1 abort = 1'b0;
      end
      drain(tag);
   endtask

   initial begin
      reset_n = 1'b0; start = 1'b0; run_len = 8'd0; repeat_cnt = 4'd0; abort = 1'b0;
      push(0, IDLE, 8'd0, 4'd0, 1'b0, 1'b0);
      push(0, IDLE, 8'd0, 4'd0, 1'b0, 1'b0);
      drain(0);
      @(posedge clk); #1 reset_n = 1'b1;

      run_seq(1, 8'd3, 4'd0, 1'b0);
      run_seq(2, 8'd2, 4'd2, 1'b0);
      run_seq(3, 8'd0, 4'd0, 1'b0);

      // start held high: IDLE/RUNNING/FINISH cadence
      @(posedge clk); #1;
      start = 1'b1; run_len = 8'd1; repeat_cnt = 4'd0;
      @(posedge clk); #1;
      repeat (3) begin
         push(4, RUN,  8'd0, 4'd0, 1'b1, 1'b0);
         push(4, FIN,  8'd0, 4'd0, 1'b0, 1'b1);
         push(4, IDLE, 8'd0, 4'd0, 1'b0, 1'b0);
      end
      push(4, IDLE, 8'd0, 4'd0, 1'b0, 1'b0);
      repeat (7) @(posedge clk);
      #1 start = 1'b0;
      drain(4);

      // async reset in the second pass, then a start right after release
      @(posedge clk); #1;
      start = 1'b1; run_len = 8'd2; repeat_cnt = 4'd2;
      @(posedge clk); #1;
      start = 1'b0;
      push(5, RUN,  8'd0, 4'd0, 1'b1, 1'b0);
      push(5, RUN,  8'd1, 4'd0, 1'b1, 1'b0);
      push(5, IDLE, 8'd0, 4'd0, 1'b0, 1'b0);
      push(5, IDLE, 8'd0, 4'd0, 1'b0, 1'b0);
      push(5, RUN,  8'd0, 4'd0, 1'b1, 1'b0);
      push(5, FIN,  8'd0, 4'd0, 1'b0, 1'b1);
      push(5, IDLE, 8'd0, 4'd0, 1'b0, 1'b0);
      @(posedge clk);
      @(posedge clk); #2 reset_n = 1'b0;
      @(posedge clk); #2;
      reset_n = 1'b1; start = 1'b1; run_len = 8'd1; repeat_cnt = 4'd0;
      @(posedge clk); #1 start = 1'b0;
      drain(5);

      // abort on the last cycle of the final pass
      run_seq(6, 8'd2, 4'd1, 1'b1);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/run_ctrl_fsm.md
RUN_CTRL_FSM -- requirements
Module: run_ctrl_fsm

Interface
REQ-001 The block SHALL have parameter CNT_W, default 8, which sets the run-length and cycle-counter width.
REQ-002 The block SHALL have parameter REP_W, default 4, which sets the repeat-count and pass-counter width.
REQ-003 The block SHALL have port clk  input  1  the single clock; all state changes on its rising edge.
REQ-004 The block SHALL have port reset_n  input  1  asynchronous, active-low reset.
REQ-005 The block SHALL have port start  input  1  request to begin a sequence; sampled only in IDLE.
REQ-006 The block SHALL have port run_len  input  CNT_W  cycles per pass; latched when start is accepted.
REQ-007 The block SHALL have port repeat_cnt  input  REP_W  number of extra passes; total passes = repeat_cnt+1; latched when start is accepted.
REQ-008 The block SHALL have port abort  input  1  cancels an active sequence; only functional with RUN_CTRL_ABORT_EN.
REQ-009 The block SHALL have port busy  output  1  high while in RUNNING.
REQ-010 The block SHALL have port done  output  1  high for exactly the one FINISH cycle.
REQ-011 The block SHALL have port state_out  output  2  encoding: IDLE=00, RUNNING=01, FINISH=10, ABORTED=11.
REQ-012 The block SHALL have port cycle_cnt  output  CNT_W  cycle index within the current pass.
REQ-013 The block SHALL have port pass_cnt  output  REP_W  index of the current pass.

Function
REQ-014 All outputs SHALL be Moore outputs, decoded from the registered state and counters only, with no combinational path from any input.
REQ-015 In IDLE with start=1, the block SHALL latch run_len and repeat_cnt, clear both counters, and enter RUNNING on the next edge.
REQ-016 The effective pass length L SHALL be run_len, with run_len=0 treated as L=1.
REQ-017 In RUNNING, cycle_cnt SHALL increment each cycle from 0 to L-1.
REQ-018 On the cycle where cycle_cnt=L-1 and pass_cnt is below the latched repeat_cnt, cycle_cnt SHALL wrap to 0, pass_cnt SHALL increment, and the state SHALL stay RUNNING.
REQ-019 On the cycle where cycle_cnt=L-1 and pass_cnt equals the latched repeat_cnt, the next state SHALL be FINISH.
REQ-020 FINISH SHALL last exactly one cycle and then return to IDLE unconditionally; start asserted during FINISH SHALL be ignored.
REQ-021 With start accepted at edge N, RUNNING SHALL begin at edge N+1 and done SHALL be high in the cycle after edge N+1+(repeat_cnt+1)*L.
REQ-022 start outside IDLE SHALL be ignored, and run_len/repeat_cnt changes after acceptance SHALL have no effect.
REQ-023 Counters SHALL hold their values in FINISH and ABORTED and be cleared on entry to RUNNING from IDLE; they hold otherwise in IDLE.
REQ-024 Any state encoding not reachable under the current configuration SHALL transition to IDLE on the next edge.

Reset
REQ-025 reset_n=0 SHALL immediately (asynchronously) force state IDLE, busy=0, done=0, state_out=00, cycle_cnt=0, pass_cnt=0, and clear the latched length and repeat values.
REQ-026 Reset asserted mid-sequence SHALL abandon the sequence with no done pulse, and the first start is accepted on the first edge after reset_n deassertion.

Configuration
REQ-027 With macro RUN_CTRL_ABORT_EN defined, abort=1 in RUNNING SHALL enter ABORTED on the next edge, taking priority over the pass-end transition, so done is not asserted.
REQ-028 ABORTED SHALL last one cycle with busy=0 and done=0, then go to IDLE; abort outside RUNNING SHALL be ignored.
REQ-029 Without RUN_CTRL_ABORT_EN, abort SHALL be ignored, ABORTED SHALL be unreachable, and state_out SHALL never equal 11.

Verification
REQ-030 Bench SHALL drive run_len=3, repeat_cnt=0, start at edge 0 -> busy high for cycles 1-3, cycle_cnt 0,1,2, done high for cycle 4 only, IDLE at cycle 5.
REQ-031 Bench SHALL drive run_len=2, repeat_cnt=2 -> 6 RUNNING cycles, pass_cnt 0,0,1,1,2,2, and a single done pulse at cycle 7.
REQ-032 Bench SHALL drive run_len=0, repeat_cnt=0 -> one RUNNING cycle, then done the following cycle.
REQ-033 Bench SHALL hold start high continuously with run_len=1, repeat_cnt=0 -> repeating IDLE, RUNNING, FINISH pattern; start ignored during RUNNING and FINISH.
REQ-034 Bench SHALL pulse reset_n low between clock edges during the 2nd pass -> outputs zero immediately and no done pulse afterwards.
REQ-035 Bench SHALL, with RUN_CTRL_ABORT_EN, assert abort on the last cycle of the final pass -> state_out=11 for one cycle, done never high, then IDLE; without the macro, the same stimulus -> normal done.
